program_loader: RTL
===================

# program_loader

Writer side of the instruction path: accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit instruction words, writes them into instruction memory at consecutive addresses, and holds the processor in reset until a complete program has been loaded. The block sits between the host/UART byte source and the instruction memory port that feeds the control unit's IR. It is the only driver of the processor's `ResetN`.

## Interface
- `ADDR_W`, default 7: instruction memory address width, giving 2^ADDR_W words.
- `Clk`, input, 1: the block's only clock; every state change occurs on its rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Start`, input, 1: single-cycle pulse that begins a load session.
- `In_data`, input, 8: stream byte, high byte of each word first.
- `In_valid`, input, 1: `In_data` holds a valid byte.
- `In_ready`, output, 1: the loader can accept a byte this cycle.
- `I_wr`, output, 1: instruction memory write enable.
- `I_addr`, output, ADDR_W: instruction memory write address.
- `I_wdata`, output, 16: instruction word to be written.
- `Cpu_ResetN`, output, 1: active-low reset to the processor and control unit.
- `Busy`, output, 1: a load session is in progress.
- `Done`, output, 1: one-cycle pulse when a program has loaded successfully.
- `Err`, output, 1: level signal; the last session failed.
- `Word_count`, output, ADDR_W+1: number of words written in the current session.

## Operation
- States: `LD_IDLE`, `LD_HI`, `LD_LO`, `LD_WRITE`, `LD_FINISH`, `LD_RUN`, `LD_ERROR`.
- `LD_IDLE`:
  - Entered from reset.
  - `Cpu_ResetN`=0.
  - `Start` moves to `LD_HI`, clears the address counter, `Word_count` and `Err`.
- `LD_HI`:
  - `In_ready`=1.
  - On `In_valid`&&`In_ready`, capture `In_data` into word[15:8] and move to `LD_LO`.
- `LD_LO`:
  - `In_ready`=1.
  - On a handshake, capture word[7:0] and move to `LD_WRITE`.
- `LD_WRITE`:
  - `I_wr`=1 for exactly one cycle, with `I_addr`=address counter and `I_wdata`=assembled word.
  - The address counter and `Word_count` increment on this cycle.
  - Next state:
    - If word[15:12]==4'h5 (HALT), go to `LD_FINISH`.
    - Otherwise, if the written address was 2^ADDR_W−1, go to `LD_ERROR` (memory full with no HALT). The counter never wraps.
    - Otherwise, go to `LD_HI`.
- `LD_FINISH`: `Done`=1 for one cycle, then `LD_RUN`.
- `LD_RUN`:
  - `Cpu_ResetN`=1.
  - `Start` drops `Cpu_ResetN` and moves to `LD_HI`, clearing counters; this is a reload.
- `LD_ERROR`:
  - `Err`=1 and `Cpu_ResetN`=0.
  - `Start` retries by moving to `LD_HI` and clearing `Err`.
- `Busy`=1 in `LD_HI`, `LD_LO`, `LD_WRITE` and `LD_FINISH`.
- `Start` is ignored while `Busy`.
- `In_valid` without a handshake in any other state is ignored. Bytes are not consumed.

## Timing
- Reset values:
  - state = `LD_IDLE`
  - `Cpu_ResetN`=0, `In_ready`=0, `I_wr`=0, `Done`=0, `Err`=0, `Busy`=0
  - `I_addr`=0, `I_wdata`=0, `Word_count`=0
- `Reset` asserted mid-session:
  - All outputs return to their reset values immediately (asynchronous).
  - A partial word is discarded.
  - `I_wr` deasserts in the same instant.
- `In_ready` decodes from registered state only. It never depends combinationally on `In_valid`.
- Minimum of 3 cycles per word, with `In_valid` held high: HI, LO, WRITE.
- The `I_wr` cycle presents stable address and data; the memory captures them on the next rising edge.
- Edge timing:
  - `Done` is high in the cycle after the HALT word's `I_wr` cycle.
  - `Cpu_ResetN` rises on the following edge and is registered (glitch-free).
- `Start` arriving on the same edge as a handshake in `LD_RUN`/`LD_IDLE` is impossible, since `In_ready`=0 there. `Start` wins.

## Configuration
- Macro: `LOADER_OPCODE_CHECK_EN`.
- Defined:
  - In `LD_WRITE`, a word with opcode 4'h6–4'hF is not written (`I_wr`=0).
  - `Word_count` is unchanged.
  - The next state is `LD_ERROR`.
- Undefined: every word is written regardless of opcode; only memory overflow produces `LD_ERROR`.

## Structure
- Shared package `cpu_pkg`:
  - The instruction opcode enum (NOOP=0, STORE=1, LOAD=2, ADD=3, SUB=4, HALT=5), also used by the control unit.
  - Constants `OP_HALT` and `OP_MAX_VALID`.
  - The loader state enum, `LoaderState`.
- Sub-module `byte_pair_assembler`:
  - Holds the hi/lo byte registers and exposes the 16-bit word.
  - Kept separate so the same block can serve a future data-memory loader.
- The FSM, address counter and output registers live in `program_loader`.

## Test plan
- Reset, then `Start`, then stream 30 0C 30 0C 50 00:
  - Writes 0x300C at address 0 and 0x500C at address 1?
  - Corrected: the stream writes 0x300C@0, 0x300C@1 and 0x5000@2.
  - `Word_count`=3, `Done` pulses once, and `Cpu_ResetN` rises one cycle later.
- `In_valid` toggled 1-0-1 between bytes: no byte is lost or duplicated, and words and addresses are identical to the continuous case.
- `ADDR_W`=2, four non-HALT words:
  - Four writes at addresses 0–3, then `Err`=1.
  - `Cpu_ResetN` stays 0 and no wrap to address 0.
- With `LOADER_OPCODE_CHECK_EN` defined, word 0x7123: no `I_wr`, `Err`=1. With the macro undefined, the word is written at address 0.
- `Reset` asserted between the hi and lo bytes, then a new session:
  - Outputs are at reset values immediately.
  - The first word of the new session lands at address 0 with the correct data.
- `Start` in `LD_RUN`: `Cpu_ResetN` drops on the next edge, `Word_count`=0, and reload proceeds.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the program loader and the control unit.
//   - opcode_e     : instruction opcodes held in word[15:12]
//   - OP_HALT      : opcode that terminates a program image
//   - OP_MAX_VALID : highest opcode the control unit decodes
//   - LoaderState  : program_loader FSM states
// No ports; import with `import cpu_pkg::*;`.
package cpu_pkg;

    typedef enum logic [3:0] {
        NOOP  = 4'h0,
        STORE = 4'h1,
        LOAD  = 4'h2,
        ADD   = 4'h3,
        SUB   = 4'h4,
        HALT  = 4'h5
    } opcode_e;

    localparam logic [3:0] OP_HALT      = 4'(HALT);
    localparam logic [3:0] OP_MAX_VALID = 4'(HALT);

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HI,
        LD_LO,
        LD_WRITE,
        LD_FINISH,
        LD_RUN,
        LD_ERROR
    } LoaderState;

    function automatic logic opcode_is_valid(input logic [3:0] op);
        return op <= OP_MAX_VALID;
    endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// byte_pair_assembler: packs two stream bytes (high byte first) into a 16-bit word.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (clears both bytes)
//   cap_hi_i     : load byte_i into word[15:8]
//   cap_lo_i     : load byte_i into word[7:0]
//   byte_i       : incoming stream byte
//   word_o       : assembled word, held until overwritten
module byte_pair_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cap_hi_i,
    input  logic        cap_lo_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] word_o
);

    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;

    always_comb begin
        hi_d = cap_hi_i ? byte_i : hi_q;
        lo_d = cap_lo_i ? byte_i : lo_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign word_o = {hi_q, lo_q};

endmodule

// File: rtl/program_loader.sv
// program_loader: loads a byte stream into instruction memory and holds the CPU in reset
// until a program ending in HALT has been written.
// Ports:
//   Clk, Reset         : clock, asynchronous active-high reset
//   Start              : pulse that begins a load (ignored while Busy)
//   In_data/In_valid   : byte stream in, high byte of each word first
//   In_ready           : byte accepted on In_valid && In_ready
//   I_wr/I_addr/I_wdata: instruction memory write port
//   Cpu_ResetN         : registered active-low processor reset
//   Busy, Done, Err    : session status (Done is a one-cycle pulse, Err a level)
//   Word_count         : words written in the current session
// Build option: define LOADER_OPCODE_CHECK_EN to reject words with opcodes above HALT.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        In_data,
    input  logic              In_valid,
    output logic              In_ready,
    output logic              I_wr,
    output logic [ADDR_W-1:0] I_addr,
    output logic [15:0]       I_wdata,
    output logic              Cpu_ResetN,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   Word_count
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    LoaderState        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              resetn_q, resetn_d;

    logic [15:0] word;
    logic        hs;
    logic        word_ok;
    logic        is_halt;
    logic        last_addr;
    logic        wr_en;
    logic        start_session;

    assign hs        = In_valid && In_ready;
    assign is_halt   = (word[15:12] == OP_HALT);
    assign last_addr = (addr_q == ADDR_LAST);
`ifdef LOADER_OPCODE_CHECK_EN
    assign word_ok   = opcode_is_valid(word[15:12]);
`else
    assign word_ok   = 1'b1;
`endif
    assign wr_en         = (state_q == LD_WRITE) && word_ok;
    assign start_session = Start &&
                           (state_q == LD_IDLE || state_q == LD_RUN || state_q == LD_ERROR);

    byte_pair_assembler u_asm (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .cap_hi_i (state_q == LD_HI && hs),
        .cap_lo_i (state_q == LD_LO && hs),
        .byte_i   (In_data),
        .word_o   (word)
    );

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= LD_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            resetn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            resetn_q <= resetn_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE, LD_RUN, LD_ERROR: if (Start) state_d = LD_HI;
            LD_HI:     if (hs) state_d = LD_LO;
            LD_LO:     if (hs) state_d = LD_WRITE;
            LD_WRITE: begin
                if (!word_ok)       state_d = LD_ERROR;
                else if (is_halt)   state_d = LD_FINISH;
                else if (last_addr) state_d = LD_ERROR;
                else                state_d = LD_HI;
            end
            LD_FINISH: state_d = LD_RUN;
            default:   state_d = LD_IDLE;
        endcase
    end

    // Counters; the address saturates at the last word instead of wrapping.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (start_session) begin
            addr_d  = '0;
            count_d = '0;
        end else if (wr_en) begin
            count_d = count_q + 1'b1;
            if (!last_addr) addr_d = addr_q + 1'b1;
        end
    end

    // CPU reset released from a flop so it cannot glitch on state decode.
    assign resetn_d = (state_d == LD_RUN);

    // Outputs
    always_comb begin
        In_ready   = (state_q == LD_HI) || (state_q == LD_LO);
        I_wr       = wr_en;
        I_addr     = addr_q;
        I_wdata    = word;
        Busy       = (state_q == LD_HI) || (state_q == LD_LO) ||
                     (state_q == LD_WRITE) || (state_q == LD_FINISH);
        Done       = (state_q == LD_FINISH);
        Err        = (state_q == LD_ERROR);
        Cpu_ResetN = resetn_q;
        Word_count = count_q;
    end

endmodule
